// File: rtl/command_burst_issuer.sv
// Pops {address, length, last} commands and splits each into read bursts that are
// capped at MAX_BURST_BYTES, never straddle a BOUNDARY_BYTES line, and respect an outstanding cap.
module command_burst_issuer #(
  parameter int MAX_BURST_BYTES = 256,
  parameter int BOUNDARY_BYTES  = 4096,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [63:0] fifo_command_address,
  input  logic [23:0] fifo_command_length,
  input  logic        fifo_last_command,
  output logic        fifo_read,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [63:0] req_address,
  output logic [12:0] req_length,
  input  logic        rsp_valid,
  output logic        busy,
  output logic        done,
  output logic        err_underflow
);

  localparam int BW = $clog2(BOUNDARY_BYTES);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t      state, state_n;
  logic [63:0] cur_addr;
  logic [23:0] remaining;
  logic [12:0] burst_len;
  logic        cmd_last;
  logic [3:0]  outstanding;
  logic        pop, hs, last_burst, drained;
  logic [63:0] next_addr;
  logic [23:0] next_rem;

  // Smallest of: bytes left, burst cap, bytes up to the next boundary.
  function automatic logic [12:0] calc_burst(input logic [63:0] addr, input logic [23:0] rem);
    logic [24:0] room, cap;
    room = 25'(BOUNDARY_BYTES) - 25'(addr[BW-1:0]);
    cap  = (room < 25'(MAX_BURST_BYTES)) ? room : 25'(MAX_BURST_BYTES);
    if ({1'b0, rem} < cap) cap = {1'b0, rem};
    return cap[12:0];
  endfunction

  assign pop        = (state == IDLE) && enable && !fifo_empty;
  assign req_valid  = (state == ISSUE) && (outstanding < 4'(MAX_OUTSTANDING));
  assign hs         = req_valid && req_ready;
  assign last_burst = (24'(burst_len) == remaining);
  assign drained    = (state == DRAIN) && (outstanding == 4'd0);
  assign next_addr  = cur_addr + 64'(burst_len);
  assign next_rem   = remaining - 24'(burst_len);

  assign fifo_read   = pop;
  assign req_address = cur_addr;
  assign req_length  = burst_len;
  assign done        = drained;
  // busy falls in the same cycle done pulses, i.e. as the FSM leaves DRAIN.
  assign busy        = (state != IDLE) && !drained;

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (pop) begin
          if (fifo_command_length != 24'd0) state_n = ISSUE;
          else if (fifo_last_command)      state_n = DRAIN;
        end
      end
      ISSUE: begin
        if (hs && last_burst) state_n = cmd_last ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (drained) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cur_addr      <= '0;
      remaining     <= '0;
      burst_len     <= '0;
      cmd_last      <= 1'b0;
      outstanding   <= '0;
      err_underflow <= 1'b0;
    end else begin
      state <= state_n;
      if (pop) begin
        cur_addr  <= fifo_command_address;
        remaining <= fifo_command_length;
        cmd_last  <= fifo_last_command;
        burst_len <= calc_burst(fifo_command_address, fifo_command_length);
      end else if (hs) begin
        // Precompute the following burst so req_length is always a flop.
        cur_addr  <= next_addr;
        remaining <= next_rem;
        burst_len <= calc_burst(next_addr, next_rem);
      end
      case ({hs, rsp_valid})
        2'b10: outstanding <= outstanding + 4'd1;
        2'b01: begin
          if (outstanding == 4'd0) err_underflow <= 1'b1;
          else                     outstanding   <= outstanding - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
